execute_stage_md: RTL and testbench
===================================

Name: execute_stage_md

Overview:
Parametrised next-generation execute stage of the 5-stage MIPS pipeline, between ID/EX and EX/MEM. Contents:
- ALU with funct decode.
- Destination-register mux.
- Two-level operand forwarding, with priority resolved as MEM over WB.
- Iterative multiply/divide unit with HI/LO registers.
- Stall handshake towards the front end while the multiply/divide unit is busy.
- Registered EX/MEM outputs.

Parameters:
DATA_W, 32, datapath width (operands, result, HI, LO).
REG_AW, 5, register-address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
data_1  in  DATA_W  rs value from register file.
data_2  in  DATA_W  rt value from register file.
imm  in  DATA_W  sign-extended immediate; imm[5:0] is funct.
rs, rt, rd  in  REG_AW  register numbers of the instruction in EX.
ex  in  4  ex[3]=reg_dst (1:rd, 0:rt); ex[2:1]=ALU_op; ex[0]=alu_src (1:imm).
md_op  in  3  0 none, 1 MULTU, 2 DIVU, 3 MFHI, 4 MFLO; 5-7 treated as 0.
m_EX  in  3  memory-stage controls, passed through.
wb_EX  in  2  write-back controls; wb_EX[0]=reg_write.
wb_write_register  in  REG_AW  destination register in WB.
wb_write_data  in  DATA_W  value being written in WB.
wb_reg_write  in  1  WB write enable.
stall  out  1  combinational; front end holds ID/EX inputs while high.
md_busy  out  1  multiply/divide iteration in progress.
res  out  DATA_W  EX/MEM result.
zero  out  1  EX/MEM zero flag (res==0 of ALU).
write_register  out  REG_AW  EX/MEM destination.
write_data_ex  out  DATA_W  EX/MEM store data (forwarded rt value).
m_MEM  out  3  EX/MEM memory controls.
wb_MEM  out  2  EX/MEM write-back controls.

Behaviour:
- Reset: all outputs, HI, LO, iteration counter and md_busy go to 0. Reset mid-iteration aborts the operation and leaves HI=LO=0.
- Forwarding, operand A (rs):
  - Take res if wb_MEM[0] && write_register!=0 && write_register==rs.
  - Otherwise take wb_write_data if wb_reg_write && wb_write_register!=0 && wb_write_register==rs.
  - Otherwise take data_1.
- Forwarding, operand B (rt): same rules against rt, falling back to data_2. The forwarded B is the value used for write_data_ex.
- ALU second operand = alu_src ? imm : forwarded B.
- ALU_op 0: ADD. ALU_op 1: SUB. ALU_op 3: result 0.
- ALU_op 2 decodes funct:
  - 32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR.
  - 42 SLT: signed compare, result 1 or 0, zero-extended.
  - Any other funct: result 0.
- All arithmetic is modulo 2^DATA_W; there are no overflow traps.
- EX result: MFHI gives HI, MFLO gives LO, all other md_op values give the ALU result.
- Multiply/divide unit:
  - An issue happens when md_op is MULTU or DIVU and stall=0. Operands are the forwarded A and B, captured at that edge.
  - md_busy is high for exactly DATA_W cycles after the issue edge. HI/LO update on the edge where md_busy falls.
  - MULTU: shift-add algorithm; {HI,LO} = unsigned A*B.
  - DIVU: restoring division; LO = quotient, HI = remainder.
  - DIVU with B=0: LO = all ones, HI = A.
- Stall rule: stall = md_busy && (md_op!=0). An instruction without a multiply/divide op flows freely during an iteration.
- While stall=1, EX/MEM captures a bubble: m_MEM=0, wb_MEM=0, res, write_register and write_data_ex all 0. No new issue happens.
- When stall=0, EX/MEM registers the instruction's res, zero, write_register, forwarded B, m_EX and wb_EX.
- Latency:
  - ALU ops: 1 cycle.
  - MFHI/MFLO issued back-to-back after MULTU/DIVU: reach EX/MEM DATA_W+1 cycles after the issue edge.

Test Plan:
- Reset state: assert reset with nonzero inputs for 2 cycles. All outputs and md_busy are 0 the cycle after reset. stall=0.
- Forwarding priority: EX/MEM holds r5=0x11, WB holds r5=0x22, rs=5, ADD with data_1=0x99. ALU uses 0x11. Repeat with EX/MEM writing r0: ALU uses 0x22.
- MULTU: 0xFFFFFFFF*2 followed immediately by MFLO then MFHI. stall is high for 32 cycles. res sequence is 0xFFFFFFFE, then 0x00000001. No bubbles are carried into register writes.
- DIVU: 100/7 gives LO=14, HI=2. DIVU 5/0 gives LO=0xFFFFFFFF, HI=5.
- Non-multiply/divide flow during busy: ADD 3+4 issued the cycle after MULTU sees stall=0 and res=7 one cycle later. md_busy remains high.
- Reset mid-iteration: reset at iteration cycle 10 of MULTU. md_busy=0 next cycle. A following MFLO returns 0 with no stall.

Source files
------------

// File: rtl/execute_stage_md.sv
// MIPS execute stage: ALU, two-level forwarding, iterative MULTU/DIVU
// with HI/LO, front-end stall and registered EX/MEM outputs.
module execute_stage_md #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        ex,
    input  logic [2:0]        md_op,
    input  logic [2:0]        m_EX,
    input  logic [1:0]        wb_EX,
    input  logic [REG_AW-1:0] wb_write_register,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              wb_reg_write,
    output logic              stall,
    output logic              md_busy,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic [REG_AW-1:0] write_register,
    output logic [DATA_W-1:0] write_data_ex,
    output logic [2:0]        m_MEM,
    output logic [1:0]        wb_MEM
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIVU  = 3'd2,
        MD_MFHI  = 3'd3,
        MD_MFLO  = 3'd4
    } md_op_e;

    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic [REG_AW-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [2:0]        m_q, m_d;
    logic [1:0]        wb_q, wb_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              is_div_q, is_div_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, ex_res;
    logic [DATA_W:0]   mul_sum, rem_sh, div_sub;
    logic              div_ge;
    logic [DATA_W-1:0] step_acc, step_sh;
    md_op_e            md_sel;
    logic              issue;

    // MEM stage result has priority over the value being written back
    always_comb begin
        if (wb_q[0] && (wr_q != '0) && (wr_q == rs)) begin
            fwd_a = res_q;
        end else if (wb_reg_write && (wb_write_register != '0)
                     && (wb_write_register == rs)) begin
            fwd_a = wb_write_data;
        end else begin
            fwd_a = data_1;
        end
        if (wb_q[0] && (wr_q != '0) && (wr_q == rt)) begin
            fwd_b = res_q;
        end else if (wb_reg_write && (wb_write_register != '0)
                     && (wb_write_register == rt)) begin
            fwd_b = wb_write_data;
        end else begin
            fwd_b = data_2;
        end
        alu_b = ex[0] ? imm : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        unique case (ex[2:1])
            2'd0: alu_res = fwd_a + alu_b;
            2'd1: alu_res = fwd_a - alu_b;
            2'd2: begin
                case (imm[5:0])
                    6'd32:   alu_res = fwd_a + alu_b;
                    6'd34:   alu_res = fwd_a - alu_b;
                    6'd36:   alu_res = fwd_a & alu_b;
                    6'd37:   alu_res = fwd_a | alu_b;
                    6'd39:   alu_res = ~(fwd_a | alu_b);
                    6'd42:   alu_res = {{(DATA_W-1){1'b0}},
                                        ($signed(fwd_a) < $signed(alu_b))};
                    default: alu_res = '0;
                endcase
            end
            2'd3: alu_res = '0;
        endcase
    end

    always_comb begin
        md_sel = MD_NONE;
        if (md_op <= 3'd4) begin
            md_sel = md_op_e'(md_op);
        end
        stall = busy_q && (md_sel != MD_NONE);
        issue = ((md_sel == MD_MULTU) || (md_sel == MD_DIVU)) && !stall;
        unique case (1'b1)
            (md_sel == MD_MFHI): ex_res = hi_q;
            (md_sel == MD_MFLO): ex_res = lo_q;
            default:             ex_res = alu_res;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q}
                 + (sh_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
        rem_sh   = {acc_q, sh_q[DATA_W-1]};
        div_sub  = rem_sh - {1'b0, opb_q};
        div_ge   = rem_sh >= {1'b0, opb_q};
        if (is_div_q) begin
            step_acc = div_ge ? div_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
            step_sh  = {sh_q[DATA_W-2:0], div_ge};
        end else begin
            step_acc = mul_sum[DATA_W:1];
            step_sh  = {mul_sum[0], sh_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        if (busy_q) begin
            acc_d = step_acc;
            sh_d  = step_sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                hi_d   = step_acc;
                lo_d   = step_sh;
            end
        end else if (issue) begin
            busy_d   = 1'b1;
            cnt_d    = CW'(DATA_W);
            acc_d    = '0;
            is_div_d = (md_sel == MD_DIVU);
            opb_d    = (md_sel == MD_DIVU) ? fwd_b : fwd_a;
            sh_d     = (md_sel == MD_DIVU) ? fwd_a : fwd_b;
        end
    end

    always_comb begin
        res_d  = '0;
        zero_d = 1'b0;
        wr_d   = '0;
        wd_d   = '0;
        m_d    = '0;
        wb_d   = '0;
        if (!stall) begin
            res_d  = ex_res;
            zero_d = (alu_res == '0);
            wr_d   = ex[3] ? rd : rt;
            wd_d   = fwd_b;
            m_d    = m_EX;
            wb_d   = wb_EX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q    <= '0;
            zero_q   <= 1'b0;
            wr_q     <= '0;
            wd_q     <= '0;
            m_q      <= '0;
            wb_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            res_q    <= res_d;
            zero_q   <= zero_d;
            wr_q     <= wr_d;
            wd_q     <= wd_d;
            m_q      <= m_d;
            wb_q     <= wb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign md_busy        = busy_q;
    assign res            = res_q;
    assign zero           = zero_q;
    assign write_register = wr_q;
    assign write_data_ex  = wd_q;
    assign m_MEM          = m_q;
    assign wb_MEM         = wb_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// Bench for execute_stage_md: directed scenarios plus randomized
// traffic against an arithmetic reference model.
module tb_execute_stage_md;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  data_1, data_2, imm;
    logic [AW-1:0] rs, rt, rd;
    logic [3:0]    ex;
    logic [2:0]    md_op, m_EX;
    logic [1:0]    wb_EX;
    logic [AW-1:0] wb_write_register;
    logic [W-1:0]  wb_write_data;
    logic          wb_reg_write;
    logic          stall, md_busy, zero;
    logic [W-1:0]  res, write_data_ex;
    logic [AW-1:0] write_register;
    logic [2:0]    m_MEM;
    logic [1:0]    wb_MEM;

    always #5 clk = ~clk;

    execute_stage_md #(.DATA_W(W), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .data_1(data_1), .data_2(data_2), .imm(imm),
        .rs(rs), .rt(rt), .rd(rd),
        .ex(ex), .md_op(md_op), .m_EX(m_EX), .wb_EX(wb_EX),
        .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data),
        .wb_reg_write(wb_reg_write),
        .stall(stall), .md_busy(md_busy),
        .res(res), .zero(zero),
        .write_register(write_register),
        .write_data_ex(write_data_ex),
        .m_MEM(m_MEM), .wb_MEM(wb_MEM)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [W-1:0]  e_res = '0, e_wd = '0, e_hi = '0, e_lo = '0;
    logic [W-1:0]  p_hi = '0, p_lo = '0;
    logic          e_zero = 1'b0;
    logic [AW-1:0] e_wr = '0;
    logic [2:0]    e_m = '0;
    logic [1:0]    e_wb = '0;
    int            busy_left = 0;
    logic          obs_stall;

    function automatic logic [W-1:0] fwd(input logic [AW-1:0] r,
                                         input logic [W-1:0] rf);
        if (e_wb[0] && e_wr != 0 && e_wr == r) return e_res;
        if (wb_reg_write && wb_write_register != 0
            && wb_write_register == r) return wb_write_data;
        return rf;
    endfunction

    function automatic logic [W-1:0] alu(input logic [W-1:0] a, b,
                                         input logic [1:0] op,
                                         input logic [5:0] f);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd3: return '0;
            default: begin
                case (f)
                    6'd32: return a + b;
                    6'd34: return a - b;
                    6'd36: return a & b;
                    6'd37: return a | b;
                    6'd39: return ~(a | b);
                    6'd42: return ($signed(a) < $signed(b)) ? 1 : 0;
                    default: return '0;
                endcase
            end
        endcase
    endfunction

    task automatic step();
        logic [W-1:0] a, b, bb, al, r;
        logic [63:0]  p;
        int           md;
        logic         st;
        #1;
        md = (md_op > 3'd4) ? 0 : int'(md_op);
        st = (busy_left > 0) && (md != 0);
        obs_stall = stall;
        chk("stall", stall, st);
        chk("md_busy", md_busy, busy_left > 0);
        a  = fwd(rs, data_1);
        b  = fwd(rt, data_2);
        bb = ex[0] ? imm : b;
        al = alu(a, bb, ex[2:1], imm[5:0]);
        r  = (md == 3) ? e_hi : (md == 4) ? e_lo : al;
        @(posedge clk);
        if (reset) begin
            e_res = '0; e_zero = 0; e_wr = '0; e_wd = '0;
            e_m = '0; e_wb = '0; e_hi = '0; e_lo = '0;
            busy_left = 0;
        end else begin
            if (st) begin
                e_res = '0; e_zero = 0; e_wr = '0; e_wd = '0;
                e_m = '0; e_wb = '0;
            end else begin
                e_res  = r;
                e_zero = (al == 0);
                e_wr   = ex[3] ? rd : rt;
                e_wd   = b;
                e_m    = m_EX;
                e_wb   = wb_EX;
            end
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    e_hi = p_hi;
                    e_lo = p_lo;
                end
            end else if (!st && (md == 1 || md == 2)) begin
                if (md == 1) begin
                    p = {32'b0, a} * {32'b0, b};
                    p_hi = p[63:32];
                    p_lo = p[31:0];
                end else if (b == 0) begin
                    p_lo = '1;
                    p_hi = a;
                end else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
                busy_left = W;
            end
        end
        #1;
        chk("res", res, e_res);
        chk("zero", zero, e_zero);
        chk("write_register", write_register, e_wr);
        chk("write_data_ex", write_data_ex, e_wd);
        chk("m_MEM", m_MEM, e_m);
        chk("wb_MEM", wb_MEM, e_wb);
    endtask

    task automatic ins(input logic [2:0] mo, input logic [3:0] e,
                       input logic [AW-1:0] s, t, d,
                       input logic [W-1:0] d1, d2, im,
                       input logic [1:0] w);
        md_op  = mo;
        ex     = e;
        rs     = s;
        rt     = t;
        rd     = d;
        data_1 = d1;
        data_2 = d2;
        imm    = im;
        wb_EX  = w;
        m_EX   = 3'b010;
    endtask

    task automatic md_run(input logic [2:0] op, input logic [W-1:0] a, b,
                          output logic [W-1:0] lo, hi,
                          output int stalls);
        wb_reg_write = 1'b0;
        ins(op, 4'b1000, 1, 2, 0, a, b, 0, 2'b00);
        step();
        ins(3'd4, 4'b1000, 1, 2, 8, 0, 0, 0, 2'b01);
        stalls = 0;
        for (int i = 0; i < W + 1; i++) begin
            step();
            if (obs_stall) stalls++;
        end
        lo = res;
        ins(3'd3, 4'b1000, 1, 2, 9, 0, 0, 0, 2'b01);
        step();
        hi = res;
    endtask

    logic [W-1:0] lo_v, hi_v, ra, rb;
    logic [63:0]  prod;
    int           ns;
    int           r;
    logic [5:0]   functs [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39,
                                 6'd42, 6'd13};

    initial begin
        reset = 1'b1;
        wb_write_register = 5'd3;
        wb_write_data = 32'hDEAD;
        wb_reg_write = 1'b1;
        ins(3'd1, 4'b1001, 1, 2, 3, 32'h5, 32'h6, 32'h7, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        step();
        step();
        chk("rst_res", res, 0);
        chk("rst_wb", wb_MEM, 0);
        chk("rst_wr", write_register, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b0;

        wb_reg_write = 1'b0;
        ins(0, 4'b1001, 1, 2, 5, 32'h11, 0, 0, 2'b01);
        step();
        wb_write_register = 5'd5;
        wb_write_data = 32'h22;
        wb_reg_write = 1'b1;
        ins(0, 4'b1001, 5, 2, 6, 32'h99, 0, 0, 2'b01);
        step();
        chk("fwd_mem", res, 32'h11);
        ins(0, 4'b1001, 1, 2, 0, 32'h11, 0, 0, 2'b01);
        step();
        ins(0, 4'b1001, 5, 2, 7, 32'h99, 0, 0, 2'b01);
        step();
        chk("fwd_wb", res, 32'h22);
        ins(0, 4'b1000, 1, 7, 8, 32'h1, 32'h55, 0, 2'b01);
        step();
        chk("fwd_b_res", res, 32'h23);
        chk("fwd_b_wd", write_data_ex, 32'h22);

        md_run(3'd1, 32'hFFFFFFFF, 32'h2, lo_v, hi_v, ns);
        chk("mul_lo", lo_v, 32'hFFFFFFFE);
        chk("mul_hi", hi_v, 32'h1);
        chk("mul_stalls", ns, W);
        md_run(3'd2, 32'd100, 32'd7, lo_v, hi_v, ns);
        chk("div_lo", lo_v, 32'd14);
        chk("div_hi", hi_v, 32'd2);
        md_run(3'd2, 32'd5, 32'd0, lo_v, hi_v, ns);
        chk("div0_lo", lo_v, 32'hFFFFFFFF);
        chk("div0_hi", hi_v, 32'd5);
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = (k == 3) ? 32'd1 : $urandom;
            prod = {32'b0, ra} * {32'b0, rb};
            md_run(3'd1, ra, rb, lo_v, hi_v, ns);
            chk("rmul_lo", lo_v, prod[31:0]);
            chk("rmul_hi", hi_v, prod[63:32]);
            rb = $urandom_range(1, 1000);
            md_run(3'd2, ra, rb, lo_v, hi_v, ns);
            chk("rdiv_lo", lo_v, ra / rb);
            chk("rdiv_hi", hi_v, ra % rb);
        end

        wb_reg_write = 1'b0;
        ins(3'd1, 4'b1000, 1, 2, 0, 32'h1234, 32'h5678, 0, 2'b00);
        step();
        ins(0, 4'b1000, 1, 2, 10, 32'd3, 32'd4, 0, 2'b01);
        step();
        chk("flow_stall", obs_stall, 0);
        chk("flow_res", res, 32'd7);
        chk("flow_busy", md_busy, 1);
        ins(0, 4'b1000, 1, 2, 0, 0, 0, 0, 2'b00);
        repeat (W) step();

        ins(3'd1, 4'b1000, 1, 2, 0, 32'h1234, 32'h10, 0, 2'b00);
        step();
        ins(0, 4'b1000, 1, 2, 0, 0, 0, 0, 2'b00);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", md_busy, 0);
        ins(3'd4, 4'b1000, 1, 2, 8, 0, 0, 0, 2'b01);
        step();
        chk("rst_mid_stall", obs_stall, 0);
        chk("rst_mid_lo", res, 0);

        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 15);
            md_op = (r >= 9) ? 3'(r - 8) : 3'd0;
            ex = 4'($urandom);
            data_1 = ($urandom_range(0, 3) == 0)
                   ? 32'($urandom_range(0, 3)) : $urandom;
            data_2 = ($urandom_range(0, 3) == 0)
                   ? 32'($urandom_range(0, 3)) : $urandom;
            imm = $urandom;
            imm[5:0] = functs[$urandom_range(0, 6)];
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            m_EX = 3'($urandom);
            wb_EX = 2'($urandom);
            wb_write_register = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            wb_reg_write = 1'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
